// File: rtl/crumb_pkg.sv
// Shared types for the crumb (radix-2, digit set {0..3}) decoder.
// Crumb k carries weight 2^k; digit values above 1 are unresolved carries.
package crumb_pkg;

  localparam int CRUMB_W = 2;

  typedef logic [CRUMB_W-1:0] crumb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } crumb_dec_state_t;

  function automatic int unsigned crumb_value(input crumb_t c);
    return {30'd0, c};
  endfunction

endpackage

// File: rtl/crumb_digit_adder.sv
// One-digit carry resolver: adds a crumb to the running carry and splits the
// sum into the emitted binary bit and the carry into the next weight.
module crumb_digit_adder
  import crumb_pkg::*;
(
  input  crumb_t     d,
  input  logic [1:0] carry_in,
  output logic       sum_bit,
  output logic [1:0] carry_out
);

  logic [2:0] s;

  // Max 3 + 3 = 6, so the carry never exceeds 3 and fits in two bits.
  assign s         = {1'b0, d} + {1'b0, carry_in};
  assign sum_bit   = s[0];
  assign carry_out = s[2:1];

endmodule

// File: rtl/crumb_decoding.sv
// Serial crumb-to-binary decoder: one crumb per clock, LSB first, with a
// carry register; valid/ready handshakes on input and output.
module crumb_decoding
  import crumb_pkg::*;
#(
  parameter int N_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*N_DIGITS-1:0]   in_crumbs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_DIGITS+1:0]     out_value,
  output logic                    non_canonical
);

  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int IN_W  = 2 * N_DIGITS;
  localparam int OUT_W = N_DIGITS + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

  crumb_dec_state_t  state_q, state_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic [1:0]        carry_q, carry_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N_DIGITS-1:0] bits_q, bits_d;
  logic [OUT_W-1:0]  out_value_q, out_value_d;
  logic              nc_q, nc_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  crumb_t     d_lo;
  logic       sum_bit;
  logic [1:0] carry_next;

  assign d_lo = shift_q[CRUMB_W-1:0];

  crumb_digit_adder u_adder (
    .d         (d_lo),
    .carry_in  (carry_q),
    .sum_bit   (sum_bit),
    .carry_out (carry_next)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    carry_d     = carry_q;
    count_d     = count_q;
    bits_d      = bits_q;
    out_value_d = out_value_q;
    nc_d        = nc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d    = in_crumbs;
          carry_d    = 2'd0;
          count_d    = '0;
          bits_d     = '0;
          nc_d       = 1'b0;
          in_ready_d = 1'b0;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        bits_d[count_q] = sum_bit;
        carry_d         = carry_next;
        nc_d            = nc_q | d_lo[1];
        shift_d         = shift_q >> CRUMB_W;
        count_d         = count_q + 1'b1;
        // The final digit's carry becomes the top two result bits.
        if (count_q == LAST_CNT) begin
          out_value_d = {carry_next, bits_d};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      carry_q     <= 2'd0;
      count_q     <= '0;
      bits_q      <= '0;
      out_value_q <= '0;
      nc_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      bits_q      <= bits_d;
      out_value_q <= out_value_d;
      nc_q        <= nc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_value     = out_value_q;
  assign non_canonical = nc_q;

endmodule

// File: tb/tb_crumb_decoding.sv
// Directed bench for crumb_decoding (N_DIGITS=8): hand-computed vectors,
// backpressure, async reset mid-decode and a short random-word stream.
module tb_crumb_decoding;
  import crumb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_crumbs;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_value;
  logic        non_canonical;

  int n_cmp = 0;
  int n_err = 0;

  crumb_decoding #(.N_DIGITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_crumbs     (in_crumbs),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_value     (out_value),
    .non_canonical (non_canonical)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] ref_val(input logic [15:0] w);
    int unsigned acc;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += crumb_value(w[2*k +: 2]) << k;
    return acc[9:0];
  endfunction

  function automatic logic ref_nc(input logic [15:0] w);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 8; k++) r |= w[2*k+1];
    return r;
  endfunction

  // Accept one word and wait (bounded) for out_valid; leaves the result held.
  task automatic send(input string tag, input logic [15:0] w, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin tick(); g++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_crumbs = w;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_crumbs = 16'h0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_retired_valid"}, out_valid, 0);
    chk({tag, "_retired_ready"}, in_ready, 1);
  endtask

  task automatic directed(input string tag, input logic [15:0] w,
                          input logic [9:0] exp_v, input logic exp_nc);
    int lat;
    send(tag, w, lat);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_value"}, out_value, exp_v);
    chk({tag, "_nc"}, non_canonical, exp_nc);
    chk({tag, "_busy"}, in_ready, 0);
    retire(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] w;
    logic [9:0]  held;
    int r;
    int guard;

    rst = 1'b1; in_valid = 1'b0; in_crumbs = 16'h0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_nc", non_canonical, 0);
    rst = 1'b0;
    tick();

    directed("a5",   16'h4411, 10'h0A5, 1'b0);
    directed("ones", 16'h5555, 10'h0FF, 1'b0);
    directed("max",  16'hFFFF, 10'h2FD, 1'b1);
    directed("top3", 16'hC000, 10'h180, 1'b1);
    directed("two",  16'h0002, 10'h002, 1'b1);

    // Backpressure: hold off the consumer while upstream offers a new word.
    send("bp", 16'hFFFF, lat);
    chk("bp_latency", lat, 8);
    in_crumbs = 16'h0001;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_value", out_value, 10'h2FD);
      chk("bp_hold_nc", non_canonical, 1);
      chk("bp_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    retire("bp");
    directed("bp_next", 16'h5555, 10'h0FF, 1'b0);

    // Async reset three decode cycles into a word.
    in_crumbs = 16'hFFFF;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_value", out_value, 0);
    chk("arst_nc", non_canonical, 0);
    tick();
    rst = 1'b0;
    tick();
    directed("after_rst", 16'h0001, 10'h001, 1'b0);

    // Random words with random consumer stalls.
    for (int n = 0; n < 4; n++) begin
      w = 16'($urandom);
      send("rnd", w, lat);
      chk("rnd_latency", lat, 8);
      chk("rnd_value", out_value, ref_val(w));
      chk("rnd_nc", non_canonical, ref_nc(w));
      held  = out_value;
      guard = 0;
      do begin
        r = (guard >= 6) ? 1 : int'($urandom_range(0, 1));
        out_ready = r[0];
        tick();
        if (r == 0) chk("rnd_stall_value", out_value, held);
        guard++;
      end while (r == 0);
      out_ready = 1'b0;
      chk("rnd_retired", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
